// File: rtl/riscv_ctrl_pipe_if.sv
// riscv_ctrl_pipe_if: control-word bundle between decode and the hazard/control pipe.
//   master : decode side  - drives the D-stage control word and BranchTakenE
//   slave  : control pipe - drives staged controls, hazard controls and counters
interface riscv_ctrl_pipe_if #(parameter int CNT_W = 16);
  // D-stage control word and E-stage branch resolution
  logic             RegWriteD;
  logic [1:0]       ResultSrcD;
  logic             MemWriteD;
  logic             JumpD;
  logic [1:0]       BranchD;
  logic             ALUSrcD;
  logic             sel_adderD;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic             BranchTakenE;
  // staged controls
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE, ResultSrcM, ResultSrcW;
  logic             MemWriteE, MemWriteM;
  logic             ALUSrcE, sel_adderE;
  logic [4:0]       RdE, RdM, RdW;
  // hazard controls
  logic             PCSrcE, StallF, StallD, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, sel_adderD,
           Rs1D, Rs2D, RdD, BranchTakenE,
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
           MemWriteE, MemWriteM, ALUSrcE, sel_adderE, RdE, RdM, RdW,
           PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           StallCount, FlushCount
  );

  modport slave (
    input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, sel_adderD,
           Rs1D, Rs2D, RdD, BranchTakenE,
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
           MemWriteE, MemWriteM, ALUSrcE, sel_adderE, RdE, RdM, RdW,
           PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           StallCount, FlushCount
  );
endinterface

// File: rtl/riscv_ctrl_pipe.sv
// riscv_ctrl_pipe: stages the decoded control word through E/M/W of a 5-stage RV32I
// core and generates stall, flush, forwarding and redirect controls, plus saturating
// stall/flush event counters.
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : riscv_ctrl_pipe_if.slave (D control word in, staged/hazard controls out)
module riscv_ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  riscv_ctrl_pipe_if.slave bus
);

  // E stage
  logic             r_reg_write_e, r_mem_write_e, r_jump_e, r_alu_src_e, r_sel_adder_e;
  logic [1:0]       r_result_src_e, r_branch_e;
  logic [4:0]       r_rs1_e, r_rs2_e, r_rd_e;
  // M stage
  logic             r_reg_write_m, r_mem_write_m;
  logic [1:0]       r_result_src_m;
  logic [4:0]       r_rd_m;
  // W stage
  logic             r_reg_write_w;
  logic [1:0]       r_result_src_w;
  logic [4:0]       r_rd_w;
  // counters
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic       w_pcsrc, w_lw_stall, w_stall, w_flush_e;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_pcsrc    = r_jump_e | ((r_branch_e != 2'b00) & bus.BranchTakenE);
  assign w_lw_stall = (r_result_src_e == 2'b01) & r_reg_write_e & (r_rd_e != 5'd0) &
                      ((r_rd_e == bus.Rs1D) | (r_rd_e == bus.Rs2D));
  // A redirect squashes the stalled instruction, so holding F/D would be pointless.
  assign w_stall    = w_lw_stall & ~w_pcsrc;
  assign w_flush_e  = w_lw_stall | w_pcsrc;

  // M has priority over W: it carries the younger value of the same register.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_reg_write_m && r_rd_m != 5'd0 && r_rd_m == r_rs1_e)      w_fwd_a = 2'b10;
    else if (r_reg_write_w && r_rd_w != 5'd0 && r_rd_w == r_rs1_e) w_fwd_a = 2'b01;
    if (r_reg_write_m && r_rd_m != 5'd0 && r_rd_m == r_rs2_e)      w_fwd_b = 2'b10;
    else if (r_reg_write_w && r_rd_w != 5'd0 && r_rd_w == r_rs2_e) w_fwd_b = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write_e <= 1'b0; r_result_src_e <= 2'b00; r_mem_write_e <= 1'b0;
      r_jump_e      <= 1'b0; r_branch_e     <= 2'b00; r_alu_src_e   <= 1'b0;
      r_sel_adder_e <= 1'b0; r_rs1_e <= 5'd0; r_rs2_e <= 5'd0; r_rd_e <= 5'd0;
      r_reg_write_m <= 1'b0; r_result_src_m <= 2'b00; r_mem_write_m <= 1'b0; r_rd_m <= 5'd0;
      r_reg_write_w <= 1'b0; r_result_src_w <= 2'b00; r_rd_w <= 5'd0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      // A flush inserts an all-zero bubble into E; E/M/W themselves never hold.
      if (w_flush_e) begin
        r_reg_write_e <= 1'b0; r_result_src_e <= 2'b00; r_mem_write_e <= 1'b0;
        r_jump_e      <= 1'b0; r_branch_e     <= 2'b00; r_alu_src_e   <= 1'b0;
        r_sel_adder_e <= 1'b0; r_rs1_e <= 5'd0; r_rs2_e <= 5'd0; r_rd_e <= 5'd0;
      end else begin
        r_reg_write_e <= bus.RegWriteD;  r_result_src_e <= bus.ResultSrcD;
        r_mem_write_e <= bus.MemWriteD;  r_jump_e       <= bus.JumpD;
        r_branch_e    <= bus.BranchD;    r_alu_src_e    <= bus.ALUSrcD;
        r_sel_adder_e <= bus.sel_adderD; r_rs1_e <= bus.Rs1D; r_rs2_e <= bus.Rs2D;
        r_rd_e        <= bus.RdD;
      end
      r_reg_write_m <= r_reg_write_e; r_result_src_m <= r_result_src_e;
      r_mem_write_m <= r_mem_write_e; r_rd_m         <= r_rd_e;
      r_reg_write_w <= r_reg_write_m; r_result_src_w <= r_result_src_m;
      r_rd_w        <= r_rd_m;
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_pcsrc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.RegWriteE  = r_reg_write_e;
  assign bus.RegWriteM  = r_reg_write_m;
  assign bus.RegWriteW  = r_reg_write_w;
  assign bus.ResultSrcE = r_result_src_e;
  assign bus.ResultSrcM = r_result_src_m;
  assign bus.ResultSrcW = r_result_src_w;
  assign bus.MemWriteE  = r_mem_write_e;
  assign bus.MemWriteM  = r_mem_write_m;
  assign bus.ALUSrcE    = r_alu_src_e;
  assign bus.sel_adderE = r_sel_adder_e;
  assign bus.RdE        = r_rd_e;
  assign bus.RdM        = r_rd_m;
  assign bus.RdW        = r_rd_w;
  assign bus.PCSrcE     = w_pcsrc;
  assign bus.StallF     = w_stall;
  assign bus.StallD     = w_stall;
  assign bus.FlushD     = w_pcsrc;
  assign bus.FlushE     = w_flush_e;
  assign bus.ForwardAE  = w_fwd_a;
  assign bus.ForwardBE  = w_fwd_b;
  assign bus.StallCount = r_stall_cnt;
  assign bus.FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
module tb_riscv_ctrl_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // D-stage stimulus, fanned out to both the wide-counter and narrow-counter instances
  logic       d_rw, d_mw, d_j, d_alu, d_sa, d_bt;
  logic [1:0] d_rs, d_br;
  logic [4:0] d_rs1, d_rs2, d_rd;

  riscv_ctrl_pipe_if #(.CNT_W(16)) bus  ();
  riscv_ctrl_pipe_if #(.CNT_W(2))  bus2 ();

  riscv_ctrl_pipe #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  riscv_ctrl_pipe #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus.RegWriteD  = d_rw;  assign bus2.RegWriteD  = d_rw;
  assign bus.ResultSrcD = d_rs;  assign bus2.ResultSrcD = d_rs;
  assign bus.MemWriteD  = d_mw;  assign bus2.MemWriteD  = d_mw;
  assign bus.JumpD      = d_j;   assign bus2.JumpD      = d_j;
  assign bus.BranchD    = d_br;  assign bus2.BranchD    = d_br;
  assign bus.ALUSrcD    = d_alu; assign bus2.ALUSrcD    = d_alu;
  assign bus.sel_adderD = d_sa;  assign bus2.sel_adderD = d_sa;
  assign bus.Rs1D       = d_rs1; assign bus2.Rs1D       = d_rs1;
  assign bus.Rs2D       = d_rs2; assign bus2.Rs2D       = d_rs2;
  assign bus.RdD        = d_rd;  assign bus2.RdD        = d_rd;
  assign bus.BranchTakenE = d_bt; assign bus2.BranchTakenE = d_bt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setd(input logic rw, input logic [1:0] rs, input logic mw, input logic j,
                      input logic [1:0] br, input logic alu, input logic sa,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    d_rw = rw; d_rs = rs; d_mw = mw; d_j = j; d_br = br; d_alu = alu; d_sa = sa;
    d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
  endtask

  task automatic nop();
    setd(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic drain();
    nop(); d_bt = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    // ---- 1: reset with random D inputs, then latency through E/M/W
    d_bt = 1'b1;
    setd(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
         1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    rst = 1'b1;
    tick(); tick();
    chk("rst_outputs", 64'({bus.RegWriteE, bus.RegWriteM, bus.RegWriteW, bus.ResultSrcE,
        bus.ResultSrcM, bus.ResultSrcW, bus.MemWriteE, bus.MemWriteM, bus.ALUSrcE,
        bus.sel_adderE, bus.RdE, bus.RdM, bus.RdW, bus.PCSrcE, bus.StallF, bus.StallD,
        bus.FlushD, bus.FlushE, bus.ForwardAE, bus.ForwardBE}), 64'(0));
    chk("rst_stallcnt", 64'(bus.StallCount), 64'(0));
    chk("rst_flushcnt", 64'(bus.FlushCount), 64'(0));
    chk("rst_cnt2", 64'({bus2.StallCount, bus2.FlushCount}), 64'(0));

    rst = 1'b0; d_bt = 1'b0;
    setd(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd7, 5'd8, 5'd9);
    tick();
    chk("lat_E", 64'({bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.ALUSrcE,
        bus.sel_adderE, bus.RdE}), 64'({1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 5'd9}));
    nop();
    tick();
    chk("lat_M", 64'({bus.RegWriteM, bus.ResultSrcM, bus.MemWriteM, bus.RdM, bus.RdE}),
        64'({1'b1, 2'b10, 1'b1, 5'd9, 5'd0}));
    tick();
    chk("lat_W", 64'({bus.RegWriteW, bus.ResultSrcW, bus.RdW, bus.RdM}),
        64'({1'b1, 2'b10, 5'd9, 5'd0}));
    drain();

    // ---- 2: load-use stall
    setd(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5);   // lw x5
    tick();
    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd5, 5'd6, 5'd10);  // add x10,x5,x6
    settle();
    chk("lu_stall", 64'({bus.StallF, bus.StallD, bus.FlushE, bus.FlushD}), 64'(4'b1110));
    tick();   // bubble enters E, D held
    chk("lu_release", 64'({bus.StallF, bus.StallD, bus.FlushE}), 64'(0));
    chk("lu_stallcnt", 64'(bus.StallCount), 64'(1));
    tick();   // add in E, lw in W
    chk("lu_fwd", 64'({bus.ForwardAE, bus.ForwardBE}), 64'({2'b01, 2'b00}));
    drain();

    // ---- 3: ALU forwarding
    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);   // add x3
    tick();
    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd3, 5'd3, 5'd4);   // sub x4,x3,x3
    tick();
    chk("fwd_M", 64'({bus.ForwardAE, bus.ForwardBE}), 64'({2'b10, 2'b10}));
    drain();

    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    nop();
    tick();
    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd3, 5'd3, 5'd4);
    tick();
    chk("fwd_W", 64'({bus.ForwardAE, bus.ForwardBE}), 64'({2'b01, 2'b01}));
    drain();

    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
    tick();
    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd3, 5'd3, 5'd4);
    tick();
    chk("fwd_MW_prio", 64'({bus.ForwardAE, bus.ForwardBE}), 64'({2'b10, 2'b10}));
    drain();

    // ---- 4: branches and jumps
    setd(1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);   // beq
    tick();
    nop(); d_bt = 1'b1;
    settle();
    chk("br_taken", 64'({bus.PCSrcE, bus.FlushD, bus.FlushE, bus.StallD}), 64'(4'b1110));
    chk("br_cnt_before", 64'(bus.FlushCount), 64'(0));
    tick();
    d_bt = 1'b0;
    settle();
    chk("br_after", 64'({bus.PCSrcE, bus.FlushCount}), 64'({1'b0, 16'd1}));
    drain();

    setd(1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
    tick();
    nop(); d_bt = 1'b0;
    settle();
    chk("br_nottaken", 64'({bus.PCSrcE, bus.FlushD, bus.FlushE}), 64'(0));
    drain();

    setd(1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1);   // jal x1
    tick();
    nop(); d_bt = 1'b0;
    settle();
    chk("jump", 64'({bus.PCSrcE, bus.FlushD, bus.FlushE}), 64'(3'b111));
    tick();
    chk("jump_cnt", 64'(bus.FlushCount), 64'(2));
    drain();

    // ---- 5: load-use and redirect together
    setd(1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5);
    tick();
    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd5, 5'd0, 5'd6);
    settle();
    chk("lu_redirect", 64'({bus.PCSrcE, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE}),
        64'(5'b10011));
    tick();
    nop();
    chk("lu_redirect_cnt", 64'({bus.StallCount, bus.FlushCount}), 64'({16'd1, 16'd3}));
    drain();

    // ---- 6: x0 is never a hazard source
    setd(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);   // lw x0
    tick();
    nop();
    settle();
    chk("x0_nostall", 64'({bus.StallD, bus.FlushE}), 64'(0));
    tick();   // lw x0 in M, nop (Rs1E=0) in E
    chk("x0_nofwd", 64'({bus.RegWriteM, bus.ForwardAE, bus.ForwardBE}), 64'({1'b1, 4'b0}));
    drain();

    // five more load-use stalls: wide counter reaches 6, 2-bit counter holds at 3
    for (int i = 0; i < 5; i++) begin
      setd(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5);
      tick();
      setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd5, 5'd0, 5'd6);
      tick();
      tick();
    end
    nop();
    chk("stallcnt_wide", 64'(bus.StallCount), 64'(6));
    chk("stallcnt_sat", 64'(bus2.StallCount), 64'(3));
    drain();

    // reset in the middle of a stall abandons it and clears the counters
    setd(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5);
    tick();
    setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd5, 5'd0, 5'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rst_mid_stall", 64'({bus.StallD, bus.StallCount, bus.FlushCount, bus.RdE}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
